// File: rtl/i281_pkg.sv
// Shared i281 ISA constants: one-hot class indices, opcode bundle layout and
// the 4-bit major opcode field. The control FSM imports this same package so
// both sides always agree on which bundle bit means which instruction class.
package i281_pkg;

   // Instruction word width, fixed by the i281 ISA
   localparam int INSTR_W = 16;

   // Opcode bundle: 23-bit one-hot class plus RX and RY register fields
   localparam int CLASS_W = 23;
   localparam int OPC_W   = 27;

   // Register field positions inside the opcode bundle
   localparam int RX_HI = 26;
   localparam int RX_LO = 25;
   localparam int RY_HI = 24;
   localparam int RY_LO = 23;

   // One-hot class bit indices
   localparam int OP_NOOP    = 0;
   localparam int OP_INPUTC  = 1;
   localparam int OP_INPUTCF = 2;
   localparam int OP_INPUTD  = 3;
   localparam int OP_INPUTDF = 4;
   localparam int OP_MOVE    = 5;
   localparam int OP_LOADI   = 6;
   localparam int OP_ADD     = 7;
   localparam int OP_ADDI    = 8;
   localparam int OP_SUB     = 9;
   localparam int OP_SUBI    = 10;
   localparam int OP_LOAD    = 11;
   localparam int OP_LOADF   = 12;
   localparam int OP_STORE   = 13;
   localparam int OP_STOREF  = 14;
   localparam int OP_SHIFTL  = 15;
   localparam int OP_SHIFTR  = 16;
   localparam int OP_CMP     = 17;
   localparam int OP_JUMP    = 18;
   localparam int OP_BRE     = 19;
   localparam int OP_BRNE    = 20;
   localparam int OP_BRG     = 21;
   localparam int OP_BRGE    = 22;

   // Major opcode, IR[15:12]
   typedef enum logic [3:0] {
      MAJ_NOOP   = 4'h0,
      MAJ_INPUT  = 4'h1,
      MAJ_MOVE   = 4'h2,
      MAJ_LOADI  = 4'h3,
      MAJ_ADD    = 4'h4,
      MAJ_ADDI   = 4'h5,
      MAJ_SUB    = 4'h6,
      MAJ_SUBI   = 4'h7,
      MAJ_LOAD   = 4'h8,
      MAJ_LOADF  = 4'h9,
      MAJ_STORE  = 4'hA,
      MAJ_STOREF = 4'hB,
      MAJ_SHIFT  = 4'hC,
      MAJ_CMP    = 4'hD,
      MAJ_JUMP   = 4'hE,
      MAJ_BRANCH = 4'hF
   } major_e;

   // Builds a one-hot class vector with only bit idx set
   function automatic logic [CLASS_W-1:0] classBit(input int idx);
      return CLASS_W'(1) << idx;
   endfunction

endpackage

// File: rtl/i281_instr_decoder.sv
// Pure combinational map from the upper IR byte to the 27-bit opcode bundle.
// The low IR byte is the immediate and never affects decode, so it is not an
// input; display and debug logic can reuse this block the same way.
module i281_instr_decoder
   import i281_pkg::*;
(
   input  logic [7:0]       irHi_i,
   output logic [OPC_W-1:0] opcode_o
);

   logic [CLASS_W-1:0] classVec;
   logic [1:0]         rxField;
   logic [1:0]         ryField;

   assign rxField = irHi_i[3:2];
   assign ryField = irHi_i[1:0];

   // Select exactly one class bit from the major opcode and its sub-field
   always_comb begin
      classVec = classBit(OP_NOOP);
      case (major_e'(irHi_i[7:4]))
         MAJ_NOOP:   classVec = classBit(OP_NOOP);
         MAJ_INPUT: begin
            case (ryField)
               2'b00:   classVec = classBit(OP_INPUTC);
               2'b01:   classVec = classBit(OP_INPUTCF);
               2'b10:   classVec = classBit(OP_INPUTD);
               default: classVec = classBit(OP_INPUTDF);
            endcase
         end
         MAJ_MOVE:   classVec = classBit(OP_MOVE);
         MAJ_LOADI:  classVec = classBit(OP_LOADI);
         MAJ_ADD:    classVec = classBit(OP_ADD);
         MAJ_ADDI:   classVec = classBit(OP_ADDI);
         MAJ_SUB:    classVec = classBit(OP_SUB);
         MAJ_SUBI:   classVec = classBit(OP_SUBI);
         MAJ_LOAD:   classVec = classBit(OP_LOAD);
         MAJ_LOADF:  classVec = classBit(OP_LOADF);
         MAJ_STORE:  classVec = classBit(OP_STORE);
         MAJ_STOREF: classVec = classBit(OP_STOREF);
         MAJ_SHIFT: begin
            if (ryField[0]) classVec = classBit(OP_SHIFTR);
            else            classVec = classBit(OP_SHIFTL);
         end
         MAJ_CMP:    classVec = classBit(OP_CMP);
         MAJ_JUMP:   classVec = classBit(OP_JUMP);
         MAJ_BRANCH: begin
            case (ryField)
               2'b00:   classVec = classBit(OP_BRE);
               2'b01:   classVec = classBit(OP_BRNE);
               2'b10:   classVec = classBit(OP_BRG);
               default: classVec = classBit(OP_BRGE);
            endcase
         end
         default:    classVec = classBit(OP_NOOP);
      endcase
   end

   // Pack the class vector and register fields into the bundle layout
   always_comb begin
      opcode_o                = '0;
      opcode_o[CLASS_W-1:0]   = classVec;
      opcode_o[RX_HI:RX_LO]   = rxField;
      opcode_o[RY_HI:RY_LO]   = ryField;
   end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end of the i281: owns the PC and IR, addresses the
// combinational instruction memory and hands the decoded bundle to the FSM.
module fetch_decode_unit
   import i281_pkg::*;
#(
   parameter int PC_W = 6
)(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               run,
   input  logic               pc_en,
   input  logic               pc_branch,
   input  logic               ir_load,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [OPC_W-1:0]   opcode_out,
   output logic [7:0]         imm_out,
   output logic [PC_W-1:0]    pc_out,
   output logic               ir_valid
);

   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               valid_q, valid_d;
   logic [PC_W-1:0]    branchOffset;
   logic [PC_W-1:0]    pcPlusOne;

   // Only the low PC_W bits of the sign-extended immediate matter modulo
   // 2^PC_W, so narrow PCs just take the low bits and wide PCs sign-extend.
   if (PC_W <= 8) begin : gNarrowPc
      assign branchOffset = ir_q[PC_W-1:0];
   end else begin : gWidePc
      assign branchOffset = {{(PC_W-8){ir_q[7]}}, ir_q[7:0]};
   end

   assign pcPlusOne = pc_q + PC_W'(1);

   // Next-state: strobes only act while run is high; the branch offset comes
   // from the IR currently held, even if a new word is loaded this same cycle
   always_comb begin
      pc_d    = pc_q;
      ir_d    = ir_q;
      valid_d = valid_q;
      if (run) begin
         if (pc_en) begin
            if (pc_branch) pc_d = pcPlusOne + branchOffset;
            else           pc_d = pcPlusOne;
         end
         if (ir_load) begin
            ir_d    = imem_rdata;
            valid_d = 1'b1;
         end
      end
   end

   // PC, IR and valid flag registers with asynchronous clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q    <= '0;
         ir_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         valid_q <= valid_d;
      end
   end

   i281_instr_decoder uDecoder (
      .irHi_i   (ir_q[15:8]),
      .opcode_o (opcode_out)
   );

   assign imem_addr = pc_q;
   assign pc_out    = pc_q;
   assign imm_out   = ir_q[7:0];
   assign ir_valid  = valid_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit: a behavioural model of the PC,
// IR and decode table is compared against the DUT on every falling edge,
// with directed scenarios pinning exact values and a randomized run on top.
module tb_fetch_decode_unit;
   import i281_pkg::*;

   localparam int PC_W  = 6;
   localparam int DEPTH = 64;

   logic              clock = 1'b0;
   logic              reset_n = 1'b1;
   logic              run = 1'b0;
   logic              pc_en = 1'b0;
   logic              pc_branch = 1'b0;
   logic              ir_load = 1'b0;
   logic [PC_W-1:0]   imem_addr;
   logic [15:0]       imem_rdata;
   logic [26:0]       opcode_out;
   logic [7:0]        imm_out;
   logic [PC_W-1:0]   pc_out;
   logic              ir_valid;

   logic [15:0]       imem [DEPTH];
   logic [15:0]       directWord = 16'h0000;
   bit                useMem = 1'b0;
   bit                checkEn = 1'b0;

   int                checks = 0;
   int                errors = 0;

   int                mPc = 0;
   logic [15:0]       mIr = 16'h0000;
   bit                mValid = 1'b0;

   // First class bit of each major opcode; sub-field selects add to it
   int                classBase [16] = '{0, 1, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19};

   always #5 clock = ~clock;

   assign imem_rdata = useMem ? imem[imem_addr] : directWord;

   fetch_decode_unit #(.PC_W(PC_W)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .run        (run),
      .pc_en      (pc_en),
      .pc_branch  (pc_branch),
      .ir_load    (ir_load),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .opcode_out (opcode_out),
      .imm_out    (imm_out),
      .pc_out     (pc_out),
      .ir_valid   (ir_valid)
   );

   // Expected bundle from the ISA table: base index plus sub-field offset
   function automatic logic [26:0] expOpcode(input logic [15:0] ir);
      int idx;
      logic [26:0] r;
      idx = classBase[ir[15:12]];
      if (ir[15:12] == 4'h1 || ir[15:12] == 4'hF) idx = idx + int'(ir[9:8]);
      else if (ir[15:12] == 4'hC)                 idx = idx + int'(ir[8]);
      r = 27'd1 << idx;
      r[26:23] = ir[11:8];
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural model: modular PC arithmetic, IR capture from the old PC
   always @(posedge clock or negedge reset_n) begin : model
      logic [15:0] word;
      int          nextPc;
      if (!reset_n) begin
         mPc    <= 0;
         mIr    <= 16'h0000;
         mValid <= 1'b0;
      end else if (run) begin
         word   = useMem ? imem[mPc] : directWord;
         nextPc = mPc;
         if (pc_en) begin
            nextPc = mPc + 1 + (pc_branch ? int'($signed(mIr[7:0])) : 0);
            nextPc = ((nextPc % DEPTH) + DEPTH) % DEPTH;
         end
         if (ir_load) begin
            mIr    <= word;
            mValid <= 1'b1;
         end
         mPc <= nextPc;
      end
   end

   // Compare every DUT output against the model on each falling edge
   always @(negedge clock) begin
      if (checkEn) begin
         checkOutput("pc_out", 32'(pc_out), 32'(mPc));
         checkOutput("imem_addr", 32'(imem_addr), 32'(mPc));
         checkOutput("opcode_out", 32'(opcode_out), 32'(expOpcode(mIr)));
         checkOutput("imm_out", 32'(imm_out), 32'(mIr[7:0]));
         checkOutput("ir_valid", 32'(ir_valid), 32'(mValid));
      end
   end

   task automatic applyStimulus(input bit r, input bit pe, input bit pb, input bit il, input logic [15:0] w);
      run        = r;
      pc_en      = pe;
      pc_branch  = pb;
      ir_load    = il;
      directWord = w;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic doReset();
      run       = 1'b0;
      pc_en     = 1'b0;
      pc_branch = 1'b0;
      ir_load   = 1'b0;
      #2 reset_n = 1'b0;
      @(negedge clock);
      #2 reset_n = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) imem[i] = 16'($urandom);
      #1 reset_n = 1'b0;
      checkEn = 1'b1;

      // Strobes while held in reset do nothing
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h4B00);
      #1;
      checkOutput("reset_pc", 32'(pc_out), 32'd0);
      checkOutput("reset_opcode", 32'(opcode_out), 32'h0000001);
      checkOutput("reset_valid", 32'(ir_valid), 32'd0);
      checkOutput("reset_imm", 32'(imm_out), 32'd0);

      // Released with run low: strobes ignored
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'h4B00);
      #1;
      checkOutput("hold_pc", 32'(pc_out), 32'd0);
      checkOutput("hold_opcode", 32'(opcode_out), 32'h0000001);
      checkOutput("hold_valid", 32'(ir_valid), 32'd0);

      // Fetch ADD RX=2 RY=3, then step the PC
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h4B00);
      #1;
      checkOutput("fetch_opcode", 32'(opcode_out), 32'h5800080);
      checkOutput("fetch_valid", 32'(ir_valid), 32'd1);
      checkOutput("fetch_pc_still", 32'(pc_out), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      #1;
      checkOutput("step_pc", 32'(pc_out), 32'd1);

      // Backward branch wrapping below zero: 0+1-2 -> 63
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'hF2FE);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      #1;
      checkOutput("branch_wrap_pc", 32'(pc_out), 32'd63);
      checkOutput("branch_wrap_opcode", 32'(opcode_out), 32'h1200000 | 32'h0000080 << 14);

      // Forward branch +5 from PC 10 -> 16
      doReset();
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'hF005);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
      #1;
      checkOutput("branch_fwd_pc", 32'(pc_out), 32'd16);

      // Simultaneous load+branch uses the old immediate (3): 4+1+3 -> 8
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h0003);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'h1300);
      #1;
      checkOutput("simul_pc", 32'(pc_out), 32'd8);
      checkOutput("simul_opcode", 32'(opcode_out), 32'h1800010);
      checkOutput("simul_imm", 32'(imm_out), 32'd0);

      // Exhaustive decode sweep of the upper IR byte
      for (int v = 0; v < 256; v++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, {8'(v), 8'($urandom)});
         #1;
         checkOutput("decode_onehot", 32'($countones(opcode_out[22:0])), 32'd1);
      end

      // Randomized run fetching from the instruction memory
      doReset();
      useMem = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom % 8) != 0, 1'($urandom), 1'($urandom), ($urandom % 3) == 0, 16'h0000);
         if (i % 700 == 699) doReset();
      end
      useMem = 1'b0;

      // Asynchronous reset between edges at PC 37
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h5A25);
      for (int i = 0; i < 37; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      #1;
      checkOutput("pre_async_pc", 32'(pc_out), 32'd37);
      pc_en = 1'b0;
      ir_load = 1'b0;
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async_pc", 32'(pc_out), 32'd0);
      checkOutput("async_opcode", 32'(opcode_out), 32'h0000001);
      checkOutput("async_imm", 32'(imm_out), 32'd0);
      checkOutput("async_valid", 32'(ir_valid), 32'd0);
      @(negedge clock);
      #2 reset_n = 1'b1;
      @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
